// File: rtl/modulo_medidor_periodo.sv
// Period / high-time meter: measures one period of an external slow square wave
// (sig_in) in clock cycles, one shot per start request, with saturation and timeout.
module modulo_medidor_periodo #(
  parameter int WIDTH = 20
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [WIDTH-1:0] periodo,
  output logic [WIDTH-1:0] alta
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [WIDTH-1:0] acnt_q, acnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] periodo_q, periodo_d;
  logic [WIDTH-1:0] alta_q, alta_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // s1/s2 resynchronise sig_in; s3 is only for edge detection, so both edges see the same latency
  always_ff @(posedge clock) begin
    if (clear) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM: begin
        if (rise)                state_d = COUNT;
        else if (acnt_q == MAX)  state_d = DONE;
      end
      COUNT:   if (rise || (cnt_q == MAX)) state_d = DONE;
      DONE:    state_d = start ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acnt_d     = acnt_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    periodo_d  = periodo_q;
    alta_d     = alta_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acnt_d     = '0;
          overflow_d = 1'b0;
        end
      end
      ARM: begin
        if (rise) begin
          cnt_d  = ONE;
          hcnt_d = ONE;
        end else if (acnt_q == MAX) begin
          periodo_d  = MAX;
          alta_d     = '0;
          overflow_d = 1'b1;
        end else begin
          acnt_d = acnt_q + ONE;
        end
      end
      COUNT: begin
        // hcnt never exceeds cnt, so only cnt needs a saturation check
        if (rise) begin
          periodo_d = cnt_q;
          alta_d    = hcnt_q;
        end else if (cnt_q == MAX) begin
          periodo_d  = MAX;
          alta_d     = hcnt_q;
          overflow_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
          if (s2_q) hcnt_d = hcnt_q + ONE;
        end
      end
      default: begin
        acnt_d = acnt_q;
      end
    endcase
    busy_d = (state_d == ARM) || (state_d == COUNT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      acnt_q     <= '0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      periodo_q  <= '0;
      alta_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      acnt_q     <= acnt_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      periodo_q  <= periodo_d;
      alta_q     <= alta_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign periodo  = periodo_q;
  assign alta     = alta_q;

endmodule

// File: tb/tb_modulo_medidor_periodo.sv
// Bench for modulo_medidor_periodo: a WIDTH=20 and a WIDTH=4 instance share sig_in/clear;
// expectations come from the recorded sig_in waveform, edge by edge.
module tb_modulo_medidor_periodo;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        sig_in = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        busy_a, done_a, ovf_a;
  logic [19:0] per_a, alt_a;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  per_b, alt_b;

  always #5 clock = ~clock;

  modulo_medidor_periodo #(.WIDTH(20)) dut_a (
    .clock(clock), .clear(clear), .sig_in(sig_in), .start(start_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .periodo(per_a), .alta(alt_a)
  );

  modulo_medidor_periodo #(.WIDTH(4)) dut_b (
    .clock(clock), .clear(clear), .sig_in(sig_in), .start(start_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .periodo(per_b), .alta(alt_b)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit hist [0:16383];
  int gen_per = 2;
  int gen_high = 1;
  int gen_base = 0;
  bit gen_lvl = 1'b0;

  // hist[e] is the sig_in value sampled by rising edge number e
  always @(posedge clock) begin
    if (cyc < 16384) hist[cyc] = sig_in;
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    if (gen_per == 0) sig_in = gen_lvl;
    else              sig_in = (((cyc - gen_base) % gen_per) < gen_high);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_wave(input int p, input int h, input bit l);
    gen_per  = p;
    gen_high = h;
    gen_lvl  = l;
    gen_base = cyc;
  endtask

  task automatic get(input int sel, output logic [31:0] b, output logic [31:0] d,
                     output logic [31:0] o, output logic [31:0] p, output logic [31:0] a);
    if (sel == 0) begin
      b = {31'd0, busy_a}; d = {31'd0, done_a}; o = {31'd0, ovf_a};
      p = {12'd0, per_a};  a = {12'd0, alt_a};
    end else begin
      b = {31'd0, busy_b}; d = {31'd0, done_b}; o = {31'd0, ovf_b};
      p = {28'd0, per_b};  a = {28'd0, alt_b};
    end
  endtask

  function automatic int find_rise(input int from, input int lim);
    int l;
    l = (lim > cyc) ? cyc : lim;
    if (l > 16384) l = 16384;
    for (int j = (from < 1 ? 1 : from); j < l; j++)
      if (hist[j] && !hist[j-1]) return j;
    return -1;
  endfunction

  function automatic int sum_hi(input int from, input int n);
    int s = 0;
    for (int j = from; j < from + n; j++) if (j < 16384 && hist[j]) s++;
    return s;
  endfunction

  // Rising edge of sig_in at sample k reaches the FSM two edges later.
  // A measurement started at edge c accepts first edges in [c+1, c+1+max].
  task automatic model(input int c, input int maxv, output int per, output int alt,
                       output int ovf, output int dedge);
    int k, k2;
    k = find_rise(c - 1, c + maxv);
    if (k < 0) begin
      per = maxv; alt = 0; ovf = 1; dedge = c + 1 + maxv;
    end else begin
      k2 = find_rise(k + 1, k + maxv + 1);
      if (k2 >= 0) begin
        per = k2 - k; alt = sum_hi(k, k2 - k); ovf = 0; dedge = k2 + 2;
      end else begin
        per = maxv; alt = sum_hi(k, maxv); ovf = 1; dedge = k + 2 + maxv;
      end
    end
  endtask

  task automatic start_pulse(input int sel, output int c);
    logic [31:0] b, d, o, p, a;
    @(negedge clock);
    c = cyc;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    get(sel, b, d, o, p, a);
    chk("busy_after_start", b, 1);
    chk("done_after_start", d, 0);
  endtask

  task automatic finish(input int sel, input int c, input string tag,
                        output int p_out, output int a_out, output int o_out);
    logic [31:0] b, d, o, p, a;
    int maxv, budget, got, e_per, e_alt, e_ovf, e_edge;
    maxv   = (sel == 0) ? (1 << 20) - 1 : 15;
    budget = (sel == 0) ? 400 : 60;
    got = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      get(sel, b, d, o, p, a);
      if (d == 1) begin
        got = cyc - 1;
        break;
      end
    end
    model(c, maxv, e_per, e_alt, e_ovf, e_edge);
    chk({tag, "_done_edge"}, got, e_edge);
    chk({tag, "_periodo"}, p, e_per);
    chk({tag, "_alta"}, a, e_alt);
    chk({tag, "_overflow"}, o, e_ovf);
    chk({tag, "_busy_in_done"}, b, 0);
    p_out = int'(p);
    a_out = int'(a);
    o_out = int'(o);
  endtask

  initial begin
    logic [31:0] b, d, o, p, a;
    int c, rp, ra, ro, k, nchg, ndone, pr, hr;

    // clear held three cycles while sig_in toggles
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      get(s, b, d, o, p, a);
      chk("rst_busy", b, 0);
      chk("rst_done", d, 0);
      chk("rst_ovf", o, 0);
      chk("rst_periodo", p, 0);
      chk("rst_alta", a, 0);
    end
    @(negedge clock);
    clear = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      get(s, b, d, o, p, a);
      chk("idle_busy", b, 0);
      chk("idle_done", d, 0);
    end

    // period 10, high 5
    set_wave(10, 5, 1'b0);
    repeat (25) @(posedge clock);
    #1;
    start_pulse(0, c);
    finish(0, c, "p10", rp, ra, ro);
    chk("p10_const_per", rp, 10);
    chk("p10_const_alta", ra, 5);
    chk("p10_const_ovf", ro, 0);

    // period 7, high 2, then hold results
    set_wave(7, 2, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    start_pulse(0, c);
    finish(0, c, "p7", rp, ra, ro);
    chk("p7_const_per", rp, 7);
    chk("p7_const_alta", ra, 2);
    nchg = 0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      get(0, b, d, o, p, a);
      if (p != rp || a != ra) nchg++;
      if (d == 1) ndone++;
    end
    chk("hold_changes", nchg, 0);
    chk("hold_done_pulses", ndone, 0);

    // WIDTH=4: edges 20 apart saturate
    set_wave(20, 10, 1'b0);
    repeat (45) @(posedge clock);
    #1;
    start_pulse(1, c);
    finish(1, c, "w4_e20", rp, ra, ro);
    chk("w4_e20_const_per", rp, 15);
    chk("w4_e20_const_ovf", ro, 1);

    // WIDTH=4: sig_in held low, then held high -> timeout
    set_wave(0, 0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    start_pulse(1, c);
    finish(1, c, "w4_lo", rp, ra, ro);
    chk("w4_lo_const_per", rp, 15);
    chk("w4_lo_const_alta", ra, 0);
    chk("w4_lo_const_ovf", ro, 1);
    set_wave(0, 0, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    start_pulse(1, c);
    finish(1, c, "w4_hi", rp, ra, ro);
    chk("w4_hi_const_ovf", ro, 1);
    chk("w4_hi_const_alta", ra, 0);

    // clear in the middle of COUNT aborts the measurement
    set_wave(10, 5, 1'b0);
    repeat (25) @(posedge clock);
    #1;
    start_pulse(0, c);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      k = find_rise(c - 1, cyc);
      if (k >= 0 && (cyc - 1) >= k + 5) break;
    end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    get(0, b, d, o, p, a);
    chk("abort_busy", b, 0);
    chk("abort_done", d, 0);
    chk("abort_ovf", o, 0);
    chk("abort_periodo", p, 0);
    chk("abort_alta", a, 0);
    ndone = 0;
    nchg = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      get(0, b, d, o, p, a);
      if (d == 1) ndone++;
      if (b == 1) nchg++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_stays_idle", nchg, 0);
    start_pulse(0, c);
    finish(0, c, "after_abort", rp, ra, ro);
    chk("after_abort_const_per", rp, 10);

    // random waveforms, each followed by a back-to-back start issued in DONE
    for (int n = 0; n < 5; n++) begin
      pr = $urandom_range(60, 3);
      hr = $urandom_range(pr - 1, 1);
      set_wave(pr, hr, 1'b0);
      repeat (3 + $urandom_range(pr + 5, 0)) @(posedge clock);
      #1;
      start_pulse(0, c);
      finish(0, c, "rnd_a", rp, ra, ro);
      start_pulse(0, c);
      finish(0, c, "rnd_a_b2b", rp, ra, ro);
    end
    for (int n = 0; n < 4; n++) begin
      pr = $urandom_range(25, 2);
      hr = $urandom_range(pr - 1, 1);
      set_wave(pr, hr, 1'b0);
      repeat (3 + $urandom_range(pr + 5, 0)) @(posedge clock);
      #1;
      start_pulse(1, c);
      finish(1, c, "rnd_b", rp, ra, ro);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
